axi_ram_reader: RTL and testbench

AXI_RAM_READER -- requirements
Module: axi_ram_reader

---
 rtl/axi_pkg.sv | 13 +
 rtl/axi_ram_reader_if.sv | 39 +++
 rtl/axi_ram_reader.sv | 137 +++++++++++++
 tb/tb_axi_ram_reader.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI encodings for the RAM reader slice.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } burst_e;

  localparam logic [2:0] RESP_OKAY   = 3'd0;
  localparam logic [2:0] RESP_SLVERR = 3'd2;

endpackage

// File: rtl/axi_ram_reader_if.sv
// AXI read-address and read-data channels bundled for the RAM reader.
interface axi_ram_reader_if #(
  parameter int AXI_DATA_W = 128,
  parameter int AXI_ADDR_W = 16,
  parameter int AXI_ID_W   = 8
);
  logic                  axi_ar_arvalid;
  logic                  axi_ar_arready;
  logic [AXI_ID_W-1:0]   axi_ar_arid;
  logic [AXI_ADDR_W-1:0] axi_ar_araddr;
  logic [3:0]            axi_ar_arregion;
  logic [7:0]            axi_ar_arlen;
  logic [2:0]            axi_ar_arsize;
  logic [1:0]            axi_ar_arburst;
  logic [3:0]            axi_ar_arcache;
  logic [2:0]            axi_ar_arprot;
  logic [3:0]            axi_ar_arqos;

  logic                  axi_r_rvalid;
  logic                  axi_r_rready;
  logic [AXI_ID_W-1:0]   axi_r_rid;
  logic [AXI_DATA_W-1:0] axi_r_rdata;
  logic [2:0]            axi_r_rresp;
  logic                  axi_r_rlast;

  modport slave (
    input  axi_ar_arvalid, axi_ar_arid, axi_ar_araddr, axi_ar_arregion, axi_ar_arlen,
           axi_ar_arsize, axi_ar_arburst, axi_ar_arcache, axi_ar_arprot, axi_ar_arqos,
           axi_r_rready,
    output axi_ar_arready, axi_r_rvalid, axi_r_rid, axi_r_rdata, axi_r_rresp, axi_r_rlast
  );

  modport master (
    output axi_ar_arvalid, axi_ar_arid, axi_ar_araddr, axi_ar_arregion, axi_ar_arlen,
           axi_ar_arsize, axi_ar_arburst, axi_ar_arcache, axi_ar_arprot, axi_ar_arqos,
           axi_r_rready,
    input  axi_ar_arready, axi_r_rvalid, axi_r_rid, axi_r_rdata, axi_r_rresp, axi_r_rlast
  );
endinterface

// File: rtl/axi_ram_reader.sv
// AXI read subordinate serving one burst at a time from a 1-cycle-latency RAM.
// Each beat walks RD (issue RAM read) then DATA (present beat until accepted).
module axi_ram_reader
  import axi_pkg::*;
#(
  parameter int AXI_DATA_W = 128,
  parameter int AXI_ADDR_W = 16,
  parameter int AXI_ID_W   = 8,
  parameter int RAM_ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  axi_ram_reader_if.slave       axi,
  output logic                  ram_rd_en,
  output logic [RAM_ADDR_W-1:0] ram_rd_addr,
  input  logic [AXI_DATA_W-1:0] ram_rd_data
);

  localparam int         LSB      = $clog2(AXI_DATA_W / 8);
  localparam logic [2:0] MAX_SIZE = 3'(LSB);

  typedef enum logic [1:0] {IDLE, RD, DATA} state_e;

  state_e                state;
  logic [AXI_ID_W-1:0]   id_q;
  logic [AXI_ADDR_W-1:0] addr_q;
  logic [AXI_ADDR_W-1:0] nxt_addr;
  logic [7:0]            len_q;
  logic [7:0]            cnt_q;
  logic [2:0]            size_q;
  logic                  incr_q;
  logic                  bad_q;   // whole burst illegal (WRAP/reserved/oversize)
  logic                  err_q;   // current beat returns SLVERR
  logic                  rd_ok;   // current beat carries RAM data
  logic                  ar_bad;
  logic                  ar_err;
  logic                  nxt_err;
  logic                  unused_sideband;

  function automatic logic out_of_range(input logic [AXI_ADDR_W-1:0] a);
    logic [AXI_ADDR_W-1:0] w;
    w = a >> LSB;
    return (w >> RAM_ADDR_W) != '0;
  endfunction

  function automatic logic [RAM_ADDR_W-1:0] word_addr(input logic [AXI_ADDR_W-1:0] a);
    return RAM_ADDR_W'(a >> LSB);
  endfunction

  // Region/cache/prot/qos carry no meaning for a plain RAM.
  assign unused_sideband = ^{axi.axi_ar_arregion, axi.axi_ar_arcache,
                             axi.axi_ar_arprot, axi.axi_ar_arqos};

  // RAM output register holds its word until the next read, so it is the beat data.
  assign axi.axi_r_rdata = rd_ok ? ram_rd_data : '0;

  // Burst legality and the address/error of the beat about to be issued.
  always_comb begin
    ar_bad   = (axi.axi_ar_arburst != BURST_FIXED && axi.axi_ar_arburst != BURST_INCR) ||
               (axi.axi_ar_arsize > MAX_SIZE);
    ar_err   = ar_bad || out_of_range(axi.axi_ar_araddr);
    nxt_addr = incr_q ? addr_q + (AXI_ADDR_W'(1) << size_q) : addr_q;
    nxt_err  = bad_q || out_of_range(nxt_addr);
  end

  // Burst FSM with registered channel and RAM outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state              <= IDLE;
      axi.axi_ar_arready <= 1'b0;
      axi.axi_r_rvalid   <= 1'b0;
      axi.axi_r_rid      <= '0;
      axi.axi_r_rresp    <= RESP_OKAY;
      axi.axi_r_rlast    <= 1'b0;
      ram_rd_en          <= 1'b0;
      ram_rd_addr        <= '0;
      id_q               <= '0;
      addr_q             <= '0;
      len_q              <= '0;
      cnt_q              <= '0;
      size_q             <= '0;
      incr_q             <= 1'b0;
      bad_q              <= 1'b0;
      err_q              <= 1'b0;
      rd_ok              <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          axi.axi_ar_arready <= 1'b1;
          if (axi.axi_ar_arvalid && axi.axi_ar_arready) begin
            axi.axi_ar_arready <= 1'b0;
            id_q        <= axi.axi_ar_arid;
            addr_q      <= axi.axi_ar_araddr;
            len_q       <= axi.axi_ar_arlen;
            size_q      <= axi.axi_ar_arsize;
            incr_q      <= (axi.axi_ar_arburst == BURST_INCR);
            bad_q       <= ar_bad;
            cnt_q       <= '0;
            err_q       <= ar_err;
            ram_rd_en   <= !ar_err;
            ram_rd_addr <= word_addr(axi.axi_ar_araddr);
            state       <= RD;
          end
        end
        RD: begin
          ram_rd_en        <= 1'b0;
          axi.axi_r_rvalid <= 1'b1;
          axi.axi_r_rid    <= id_q;
          axi.axi_r_rresp  <= err_q ? RESP_SLVERR : RESP_OKAY;
          axi.axi_r_rlast  <= (cnt_q == len_q);
          rd_ok            <= !err_q;
          state            <= DATA;
        end
        DATA: begin
          if (axi.axi_r_rready) begin
            axi.axi_r_rvalid <= 1'b0;
            axi.axi_r_rlast  <= 1'b0;
            rd_ok            <= 1'b0;
            if (axi.axi_r_rlast) begin
              axi.axi_ar_arready <= 1'b1;
              state              <= IDLE;
            end else begin
              addr_q      <= nxt_addr;
              cnt_q       <= cnt_q + 8'd1;
              err_q       <= nxt_err;
              ram_rd_en   <= !nxt_err;
              ram_rd_addr <= word_addr(nxt_addr);
              state       <= RD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_ram_reader.sv
// Bench for axi_ram_reader: directed corner bursts plus random bursts,
// each compared beat-by-beat against a burst-level reference model.

// Single-port RAM stand-in with one cycle of read latency.
module ram_1r_model #(
  parameter int AW = 8,
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          en,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] q
);
  logic [DW-1:0] mem [0:(1<<AW)-1];
  initial q = '0;
  // Registered read.
  always @(posedge clk) if (en) q <= mem[addr];
endmodule

module tb_axi_ram_reader;
  localparam int DW = 128;
  localparam int AW = 16;
  localparam int IW = 8;
  localparam int RW = 8;

  typedef struct {
    logic [DW-1:0] data;
    logic [2:0]    resp;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ram_rd_en;
  logic [RW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;
  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] mem_ref [0:(1<<RW)-1];
  logic [RW-1:0] rd_log [$];

  axi_ram_reader_if #(.AXI_DATA_W(DW), .AXI_ADDR_W(AW), .AXI_ID_W(IW)) axi();

  axi_ram_reader #(.AXI_DATA_W(DW), .AXI_ADDR_W(AW), .AXI_ID_W(IW), .RAM_ADDR_W(RW)) dut (
    .clk         (clk),
    .rst         (rst),
    .axi         (axi),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data)
  );

  ram_1r_model #(.AW(RW), .DW(DW)) u_ram (
    .clk  (clk),
    .en   (ram_rd_en),
    .addr (ram_rd_addr),
    .q    (ram_rd_data)
  );

  always #5 clk = ~clk;

  // Log every RAM read the DUT issues.
  always @(negedge clk) if (ram_rd_en) rd_log.push_back(ram_rd_addr);

  // Hard stop in case the stimulus itself wedges.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_rvalid", axi.axi_r_rvalid, 0);
    chk("rst_rlast", axi.axi_r_rlast, 0);
    chk("rst_rid", axi.axi_r_rid, 0);
    chk("rst_rdata", axi.axi_r_rdata, 0);
    chk("rst_rresp", axi.axi_r_rresp, 0);
    chk("rst_ram_en", ram_rd_en, 0);
    chk("rst_ram_addr", ram_rd_addr, 0);
    chk("rst_arready", axi.axi_ar_arready, 0);
  endtask

  // Issue one burst and check every beat; stall_beat holds rready low for
  // stall_cyc extra cycles on that beat; abort_beat pulls reset on that beat.
  task automatic do_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                          input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input int stall_beat,
                          input int stall_cyc, input int abort_beat);
    beat_t         exp_q [$];
    logic [RW-1:0] exp_rd [$];
    beat_t         e;
    logic          bad;
    int            a, n, L;
    L   = int'(len);
    bad = (burst >= 2'd2) || (size > 3'd4);
    for (int i = 0; i <= L; i++) begin
      a = (burst == 2'd1) ? ((int'(addr) + i * (1 << size)) & 32'hFFFF) : int'(addr);
      if (bad || (a >> 4) >= 256) begin
        e.data = '0;
        e.resp = 3'd2;
      end else begin
        e.data = mem_ref[a >> 4];
        e.resp = 3'd0;
        exp_rd.push_back(RW'(a >> 4));
      end
      e.last = (i == L);
      exp_q.push_back(e);
    end

    rd_log.delete();
    axi.axi_r_rready = (stall_beat != 0);
    @(negedge clk);
    n = 0;
    while (!axi.axi_ar_arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ar_ready_idle", axi.axi_ar_arready, 1);
    axi.axi_ar_arid     = id;
    axi.axi_ar_araddr   = addr;
    axi.axi_ar_arlen    = len;
    axi.axi_ar_arsize   = size;
    axi.axi_ar_arburst  = burst;
    axi.axi_ar_arregion = 4'($urandom);
    axi.axi_ar_arcache  = 4'($urandom);
    axi.axi_ar_arprot   = 3'($urandom);
    axi.axi_ar_arqos    = 4'($urandom);
    axi.axi_ar_arvalid  = 1'b1;
    @(posedge clk);
    #1 axi.axi_ar_arvalid = 1'b0;

    for (int b = 0; b <= L; b++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!axi.axi_r_rvalid && n < 20);
      chk("r_latency", n, 2);
      if (!axi.axi_r_rvalid) return;
      e = exp_q[b];
      chk("r_data", axi.axi_r_rdata, e.data);
      chk("r_resp", axi.axi_r_rresp, e.resp);
      chk("r_id", axi.axi_r_rid, id);
      chk("r_last", axi.axi_r_rlast, e.last);
      chk("ar_ready_busy", axi.axi_ar_arready, 0);
      if (b == abort_beat) begin
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs();
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_arready", axi.axi_ar_arready, 1);
        chk("post_rst_rvalid", axi.axi_r_rvalid, 0);
        return;
      end
      if (b == stall_beat) begin
        for (int k = 0; k < stall_cyc; k++) begin
          @(negedge clk);
          chk("stall_rvalid", axi.axi_r_rvalid, 1);
          chk("stall_data", axi.axi_r_rdata, e.data);
          chk("stall_id", axi.axi_r_rid, id);
          chk("stall_last", axi.axi_r_rlast, e.last);
          chk("stall_arready", axi.axi_ar_arready, 0);
        end
        axi.axi_r_rready = 1'b1;
      end
      @(posedge clk);
      #1 axi.axi_r_rready = (b + 1 != stall_beat);
    end
    @(negedge clk);
    chk("done_arready", axi.axi_ar_arready, 1);
    chk("done_rvalid", axi.axi_r_rvalid, 0);
    chk("ram_read_count", rd_log.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++)
      chk("ram_read_addr", rd_log[i], exp_rd[i]);
  endtask

  initial begin
    int r;
    logic [1:0] bt;
    logic [7:0] ln;
    logic [2:0] sz;
    axi.axi_ar_arvalid  = 1'b0;
    axi.axi_ar_arid     = '0;
    axi.axi_ar_araddr   = '0;
    axi.axi_ar_arregion = '0;
    axi.axi_ar_arlen    = '0;
    axi.axi_ar_arsize   = '0;
    axi.axi_ar_arburst  = '0;
    axi.axi_ar_arcache  = '0;
    axi.axi_ar_arprot   = '0;
    axi.axi_ar_arqos    = '0;
    axi.axi_r_rready    = 1'b1;
    for (int i = 0; i < (1 << RW); i++) begin
      mem_ref[i]   = {$urandom, $urandom, $urandom, $urandom};
      u_ram.mem[i] = mem_ref[i];
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst = 1'b1;

    // INCR from word 2, four beats
    do_burst(8'h5A, 16'h0020, 8'd3, 3'd4, 2'd1, -1, 0, -1);
    // FIXED at word 4, three beats
    do_burst(8'h11, 16'h0040, 8'd2, 3'd4, 2'd0, -1, 0, -1);
    // WRAP: all SLVERR, no RAM reads
    do_burst(8'h22, 16'h0000, 8'd1, 3'd4, 2'd2, -1, 0, -1);
    // Reserved burst type
    do_burst(8'h23, 16'h0010, 8'd2, 3'd4, 2'd3, -1, 0, -1);
    // Crossing the top of the RAM: word 255 OKAY, word 256 SLVERR
    do_burst(8'h33, 16'h0FF0, 8'd1, 3'd4, 2'd1, -1, 0, -1);
    // rready stall on beat 2
    do_burst(8'h44, 16'h0100, 8'd3, 3'd4, 2'd1, 1, 5, -1);
    // Oversize arsize
    do_burst(8'h55, 16'h0200, 8'd1, 3'd5, 2'd1, -1, 0, -1);
    // Address wraps around 2^16 back into the RAM
    do_burst(8'h66, 16'hFFF0, 8'd1, 3'd4, 2'd1, -1, 0, -1);
    // Narrow INCR: several beats share a RAM word
    do_burst(8'h67, 16'h0038, 8'd4, 3'd2, 2'd1, -1, 0, -1);
    // Reset during beat 3 of an eight-beat burst, then a clean burst
    do_burst(8'h77, 16'h0300, 8'd7, 3'd4, 2'd1, -1, 0, 2);
    do_burst(8'h78, 16'h0500, 8'd2, 3'd4, 2'd1, -1, 0, -1);

    // Random bursts
    for (int t = 0; t < 16; t++) begin
      r  = $urandom_range(0, 7);
      bt = (r < 4) ? 2'd1 : (r < 6) ? 2'd0 : 2'(r - 4);
      ln = 8'($urandom_range(0, 6));
      sz = 3'($urandom_range(0, 5));
      do_burst(8'($urandom), 16'($urandom_range(0, 16'h10FF)), ln, sz, bt,
               $urandom_range(0, 7), $urandom_range(1, 3), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
